fetch_stage: RTL

- Instruction-fetch stage that sits directly upstream of the opcode decoder.
- Holds the PC and issues word-addressed reads to a synchronous instruction memory with 1-cycle latency.
- Presents a registered instruction, its opcode and its PC to decode through a valid/stall handshake.
- Handles branch redirection from the execute stage (PCSrc qualified by the branch condition), back-pressure stalls, and a one-entry skid buffer so no fetched word is lost.

---
 rtl/fetch_stage_if.sv | 34 +++
 rtl/fetch_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
// Fetch-stage bundle: execute-stage redirect, instruction-memory read port and
// the decode-facing instruction register with its stall.
//   master : the fetch stage (drives imem request and decode outputs)
//   slave  : the surrounding pipeline / memory (drives stall, redirect, rdata)
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 24
);
  // decode back-pressure and execute-stage redirect
  logic               stall_i;
  logic               branch_taken_i;
  logic [PC_W-1:0]    branch_target_i;
  // instruction-memory read port (1-cycle latency)
  logic               imem_en_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic [INSTR_W-1:0] imem_rdata_i;
  // decode-facing instruction register
  logic               valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic [3:0]         opcode_o;
  logic [PC_W-1:0]    pc_o;
  logic [PC_W-1:0]    pc_plus1_o;

  modport master (
    input  stall_i, branch_taken_i, branch_target_i, imem_rdata_i,
    output imem_en_o, imem_addr_o, valid_o, instr_o, opcode_o, pc_o, pc_plus1_o
  );

  modport slave (
    output stall_i, branch_taken_i, branch_target_i, imem_rdata_i,
    input  imem_en_o, imem_addr_o, valid_o, instr_o, opcode_o, pc_o, pc_plus1_o
  );
endinterface

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage. Holds the PC, issues word reads to a synchronous
// instruction memory and presents a registered instruction/opcode/PC to decode.
// A one-entry skid buffer catches the word that lands while decode stalls;
// a taken branch flushes everything in flight and redirects the PC.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fetch_stage_if.master (redirect, imem port, decode outputs)
module fetch_stage #(
  parameter int unsigned           PC_W      = 16,
  parameter int unsigned           INSTR_W   = 24,
  parameter logic [PC_W-1:0]       RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = INSTR_W'(24'h900000)
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  localparam int unsigned OPC_W = 4;

  // PC / in-flight read tracking
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  // skid entry
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  // decode-facing output register
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;

  logic               imem_en_c;

  // Issue only when decode can take the stream and nothing is redirecting it;
  // this keeps at most one word outstanding while stalled.
  assign imem_en_c = rst_n & ~bus.stall_i & ~bus.branch_taken_i;

  assign bus.imem_en_o   = imem_en_c;
  assign bus.imem_addr_o = pc_q;
  assign bus.valid_o     = valid_q;
  assign bus.instr_o     = instr_q;
  assign bus.pc_o        = out_pc_q;
  assign bus.opcode_o    = instr_q[INSTR_W-1 -: OPC_W];
  assign bus.pc_plus1_o  = out_pc_q + PC_W'(1);

  // Next-state logic for PC, in-flight tracking, skid and output register
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    out_pc_d      = out_pc_q;

    if (imem_en_c) begin
      pc_d          = pc_q + PC_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (bus.branch_taken_i) begin
      // Flush: drop the in-flight word, the skid entry and the wrong-path output
      pc_d         = bus.branch_target_i;
      inflight_d   = 1'b0;
      skid_valid_d = 1'b0;
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
    end else if (bus.stall_i) begin
      // Output holds; a word returning now would otherwise be lost
      if (inflight_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = bus.imem_rdata_i;
        skid_pc_d    = inflight_pc_q;
      end
    end else if (skid_valid_q) begin
      // Skid is older than anything in flight, so it drains first
      skid_valid_d = 1'b0;
      valid_d      = 1'b1;
      instr_d      = skid_instr_q;
      out_pc_d     = skid_pc_q;
    end else if (inflight_q) begin
      valid_d  = 1'b1;
      instr_d  = bus.imem_rdata_i;
      out_pc_d = inflight_pc_q;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc_q     <= '0;
      valid_q       <= 1'b0;
      instr_q       <= NOP_INSTR;
      out_pc_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      out_pc_q      <= out_pc_d;
    end
  end

endmodule
